// File: rtl/sdram_arbiter_if.sv
// Requester-side and controller-side signal bundle for sdram_arbiter.
// slave = the arbiter's view, master = the view of whatever drives it.
interface sdram_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]            req_wbeat;
    logic [DATA_WIDTH-1:0]           rd_data;
    logic [NUM_PORTS-1:0]            rd_valid;
    logic [NUM_PORTS-1:0]            req_done;
    logic [1:0]                      sdram_command;
    logic [ADDR_WIDTH-1:0]           sdram_address;
    logic [DATA_WIDTH-1:0]           sdram_write_data;
    logic [DATA_WIDTH-1:0]           sdram_read_data;
    logic                            sdram_read_valid;
    logic                            sdram_write_done;

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
               sdram_read_data, sdram_read_valid, sdram_write_done,
        output req_wbeat, rd_data, rd_valid, req_done,
               sdram_command, sdram_address, sdram_write_data
    );

    modport master (
        output req_valid, req_write, req_address, req_wdata,
               sdram_read_data, sdram_read_valid, sdram_write_done,
        input  req_wbeat, rd_data, rd_valid, req_done,
               sdram_command, sdram_address, sdram_write_data
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller user port between
// NUM_PORTS requesters. One transaction in flight at a time; the command is
// held until the controller's first beat indicator, then beats are counted
// and the owner gets a single-cycle req_done.
module sdram_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int ADDR_WIDTH        = 24,
    parameter int DATA_WIDTH        = 16,
    parameter int READ_BURST_LENGTH = 1,
    parameter int WRITE_BURST       = 1
) (
    input logic            clk,
    input logic            rst_n,
    sdram_arbiter_if.slave bus
);
    localparam int PTR_W       = $clog2(NUM_PORTS);
    localparam int CNT_W       = $clog2(8) + 1;
    localparam int WRITE_BEATS = (WRITE_BURST != 0) ? READ_BURST_LENGTH : 1;
    localparam logic [PTR_W:0] NUM_PORTS_W = (PTR_W + 1)'(NUM_PORTS);

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, DONE} state_t;

    state_t                state;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant;
    logic [PTR_W-1:0]      pick;
    logic                  found;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      beat_total;
    logic                  beat;
    logic                  active;

    assign active     = (state == ISSUE) || (state == BURST);
    assign beat       = is_write ? bus.sdram_write_done : bus.sdram_read_valid;
    assign beat_total = is_write ? CNT_W'(WRITE_BEATS) : CNT_W'(READ_BURST_LENGTH);
    assign bus.sdram_address = addr_q;

    // Round-robin search: first valid port at or after rr_ptr, with wrap.
    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        logic [PTR_W:0] idx;
        found = 1'b0;
        pick  = rr_ptr;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (idx >= NUM_PORTS_W) idx = idx - NUM_PORTS_W;
            if (!found && bus.req_valid[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
    end

    // Select the winner's address and the owner's current write beat.
    always_comb begin
        pick_addr            = bus.req_address[ADDR_WIDTH-1:0];
        bus.sdram_write_data = bus.req_wdata[DATA_WIDTH-1:0];
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick == PTR_W'(p))  pick_addr = bus.req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (grant == PTR_W'(p)) bus.sdram_write_data = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Tell the owner its write beat is consumed this cycle.
    always_comb begin
        bus.req_wbeat = '0;
        if (active && is_write && bus.sdram_write_done) bus.req_wbeat[grant] = 1'b1;
    end

    // Transaction FSM: arbitrate, hold command until first beat, count beats, complete.
    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant             <= '0;
            is_write          <= 1'b0;
            addr_q            <= '0;
            beat_cnt          <= '0;
            bus.sdram_command <= CMD_IDLE;
            bus.req_done      <= '0;
        end else begin
            bus.req_done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant             <= pick;
                        addr_q            <= pick_addr;
                        is_write          <= bus.req_write[pick];
                        bus.sdram_command <= bus.req_write[pick] ? CMD_WRITE : CMD_READ;
                        beat_cnt          <= '0;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Drop the command right away so the controller cannot
                    // see it again when it returns to idle.
                    if (beat) begin
                        bus.sdram_command <= CMD_IDLE;
                        beat_cnt          <= CNT_W'(1);
                        if (beat_total == CNT_W'(1)) begin
                            bus.req_done[grant] <= 1'b1;
                            state               <= DONE;
                        end else begin
                            state <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt + CNT_W'(1) == beat_total) begin
                            bus.req_done[grant] <= 1'b1;
                            state               <= DONE;
                        end
                    end
                end
                DONE: begin
                    rr_ptr <= (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + PTR_W'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register read data and steer its valid to the owner of a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= '0;
        end else begin
            bus.rd_data  <= bus.sdram_read_data;
            bus.rd_valid <= '0;
            if (active && !is_write && bus.sdram_read_valid) bus.rd_valid[grant] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: two instances (burst-1 without write bursts, and
// burst-4 with write bursts) each driven by a small controller model that
// pushes expected read data / accepted addresses into scoreboard queues.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
    sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b4 ();

    sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .READ_BURST_LENGTH(1), .WRITE_BURST(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                    .READ_BURST_LENGTH(4), .WRITE_BURST(1))
        dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    // Controller model state, index 0 -> b1 (1 beat), index 1 -> b4 (4 beats).
    int m_state[2];
    int m_cnt[2];
    int m_beat[2];
    int m_stall[2];
    int m_lat[2];
    int m_txn[2];
    logic m_wr[2];
    logic [DW-1:0] m_seq[2];

    logic [DW-1:0] rq1[$];
    logic [DW-1:0] rq4[$];
    logic [AW-1:0] aq1[$];
    logic [AW-1:0] aq4[$];
    logic [DW-1:0] wr_got[$];

    function automatic logic [AW-1:0] port_addr(input int p);
        return AW'(24'h010123 + p * 24'h111000);
    endfunction

    // Model: accepts a command only when idle (after any stall), waits
    // m_lat cycles, then emits consecutive beat indicators.
    task automatic model_tick(input int d, input logic [1:0] cmd, input logic [DW-1:0] wdata,
                              input logic [AW-1:0] addr, output logic rv, output logic wd,
                              output logic [DW-1:0] rdat);
        int beats;
        rv = 1'b0; wd = 1'b0; rdat = '0;
        beats = (d == 0) ? 1 : 4;
        case (m_state[d])
            0: if (cmd != 2'd0) begin
                if (m_stall[d] > 0) m_stall[d]--;
                else begin
                    m_txn[d]++;
                    m_wr[d] = (cmd == 2'd1);
                    m_cnt[d] = m_lat[d];
                    m_state[d] = 1;
                    if (d == 0) aq1.push_back(addr); else aq4.push_back(addr);
                end
            end
            1: if (m_cnt[d] > 0) m_cnt[d]--; else begin m_state[d] = 2; m_beat[d] = 0; end
            default: ;
        endcase
        if (m_state[d] == 2) begin
            if (m_wr[d]) begin
                wd = 1'b1;
                wr_got.push_back(wdata);
            end else begin
                rv = 1'b1;
                rdat = 16'hA5A5 + m_seq[d];
                m_seq[d]++;
                if (d == 0) rq1.push_back(rdat); else rq4.push_back(rdat);
            end
            m_beat[d]++;
            if (m_beat[d] == beats) m_state[d] = 0;
        end
    endtask

    initial begin
        logic rv, wd;
        logic [DW-1:0] rd;
        b1.sdram_read_valid = 1'b0; b1.sdram_write_done = 1'b0; b1.sdram_read_data = '0;
        forever begin
            @(posedge clk); #2;
            model_tick(0, b1.sdram_command, b1.sdram_write_data, b1.sdram_address, rv, wd, rd);
            b1.sdram_read_valid = rv; b1.sdram_write_done = wd; b1.sdram_read_data = rd;
        end
    end

    initial begin
        logic rv, wd;
        logic [DW-1:0] rd;
        b4.sdram_read_valid = 1'b0; b4.sdram_write_done = 1'b0; b4.sdram_read_data = '0;
        forever begin
            @(posedge clk); #2;
            model_tick(1, b4.sdram_command, b4.sdram_write_data, b4.sdram_address, rv, wd, rd);
            b4.sdram_read_valid = rv; b4.sdram_write_done = wd; b4.sdram_read_data = rd;
        end
    end

    task automatic test_reset();
        checks++;
        if ({b1.sdram_command, b1.rd_valid, b1.req_done, b1.req_wbeat, b1.rd_data} !== '0) begin
            errors++; $display("FAIL reset_b1 outputs got %h want 0",
                {b1.sdram_command, b1.rd_valid, b1.req_done, b1.req_wbeat, b1.rd_data});
        end
        checks++;
        if (b4.sdram_command !== 2'd0) begin errors++; $display("FAIL reset_cmd got %0d want 0", b4.sdram_command); end
        checks++;
        if (b4.rd_valid !== 4'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0000", b4.rd_valid); end
        checks++;
        if (b4.req_done !== 4'b0) begin errors++; $display("FAIL reset_req_done got %b want 0000", b4.req_done); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (b4.sdram_command !== 2'd0) begin errors++; $display("FAIL idle_cmd got %0d want 0", b4.sdram_command); end
    endtask

    task automatic test_single_read();
        int cmd_cycles = 0, rv_cnt = 0, done_cnt = 0, extra = 0, txn0;
        logic [DW-1:0] exp;
        txn0 = m_txn[0];
        b1.req_address[2*AW +: AW] = port_addr(2);
        b1.req_write[2] = 1'b0;
        b1.req_valid[2] = 1'b1;
        for (int c = 0; c < 40 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (b1.sdram_command == 2'd2) cmd_cycles++;
            if (|b1.rd_valid) begin
                rv_cnt++;
                checks++;
                if (b1.rd_valid !== 4'b0100) begin errors++; $display("FAIL sr_rd_valid got %b want 0100", b1.rd_valid); end
                checks++;
                if (b1.rd_data !== 16'hA5A5) begin errors++; $display("FAIL sr_rd_data got %h want a5a5", b1.rd_data); end
                exp = (rq1.size() > 0) ? rq1.pop_front() : 16'hxxxx;
                checks++;
                if (b1.rd_data !== exp) begin errors++; $display("FAIL sr_scoreboard got %h want %h", b1.rd_data, exp); end
            end
            if (b1.req_done[2]) begin done_cnt++; b1.req_valid[2] = 1'b0; end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b1.req_done != 4'b0 || b1.sdram_command != 2'd0 || b1.rd_valid != 4'b0) extra++;
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL sr_done got %0d want 1", done_cnt); end
        checks++;
        if (cmd_cycles != 4) begin errors++; $display("FAIL sr_cmd_cycles got %0d want 4", cmd_cycles); end
        checks++;
        if (rv_cnt != 1) begin errors++; $display("FAIL sr_rv_count got %0d want 1", rv_cnt); end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL sr_quiet_after got %0d want 0", extra); end
        checks++;
        if (m_txn[0] - txn0 != 1) begin errors++; $display("FAIL sr_txn got %0d want 1", m_txn[0] - txn0); end
        exp = '0;
        checks++;
        if (aq1.size() != 1 || aq1[0] !== port_addr(2)) begin
            errors++; $display("FAIL sr_address got %h (n=%0d) want %h", (aq1.size() > 0) ? aq1[0] : 24'h0, aq1.size(), port_addr(2));
        end
        aq1.delete();
    endtask

    task automatic test_burst_write();
        int nb = 1, wbeats = 0, done_cnt = 0, other = 0;
        bit adv = 1'b0;
        wr_got.delete();
        b4.req_wdata[DW-1:0] = DW'(1);
        b4.req_address[AW-1:0] = port_addr(0);
        b4.req_write[0] = 1'b1;
        b4.req_valid[0] = 1'b1;
        for (int c = 0; c < 60 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            if (adv) begin nb++; b4.req_wdata[DW-1:0] = DW'(nb); adv = 1'b0; end
            @(negedge clk);
            if (b4.req_wbeat[0]) begin wbeats++; adv = 1'b1; end
            if (b4.req_wbeat[3:1] != 3'b0 || b4.req_done[3:1] != 3'b0) other++;
            if (b4.req_done[0]) begin done_cnt++; b4.req_valid[0] = 1'b0; b4.req_write[0] = 1'b0; end
        end
        checks++;
        if (wbeats != 4) begin errors++; $display("FAIL bw_wbeat got %0d want 4", wbeats); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL bw_done got %0d want 1", done_cnt); end
        checks++;
        if (other != 0) begin errors++; $display("FAIL bw_other_ports got %0d want 0", other); end
        checks++;
        if (wr_got.size() != 4) begin errors++; $display("FAIL bw_beats_rx got %0d want 4", wr_got.size()); end
        for (int i = 0; i < wr_got.size() && i < 4; i++) begin
            checks++;
            if (wr_got[i] !== DW'(i + 1)) begin errors++; $display("FAIL bw_data[%0d] got %0d want %0d", i, wr_got[i], i + 1); end
        end
        checks++;
        if (aq4.size() != 1 || aq4[0] !== port_addr(0)) begin errors++; $display("FAIL bw_address n=%0d want %h", aq4.size(), port_addr(0)); end
        aq4.delete();
    endtask

    task automatic test_round_robin();
        int exp_order[$];
        int done_cnt = 0, txn0;
        logic [NP-1:0] oh;
        logic [DW-1:0] exp;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rq1.delete(); aq1.delete();
        txn0 = m_txn[0];
        exp_order = '{0, 1, 2, 3, 0};
        for (int p = 0; p < NP; p++) b1.req_address[p*AW +: AW] = port_addr(p);
        b1.req_write = '0;
        b1.req_valid = '1;
        for (int c = 0; c < 200 && done_cnt < 5; c++) begin
            @(negedge clk);
            oh = 4'b0001 << exp_order[done_cnt];
            if (|b1.rd_valid) begin
                checks++;
                if (b1.rd_valid !== oh) begin errors++; $display("FAIL rr_rd_valid got %b want %b", b1.rd_valid, oh); end
                exp = (rq1.size() > 0) ? rq1.pop_front() : 16'hxxxx;
                checks++;
                if (b1.rd_data !== exp) begin errors++; $display("FAIL rr_rd_data got %h want %h", b1.rd_data, exp); end
            end
            if (|b1.req_done) begin
                checks++;
                if (b1.req_done !== oh) begin errors++; $display("FAIL rr_grant_order got %b want %b", b1.req_done, oh); end
                done_cnt++;
                if (done_cnt == 5) b1.req_valid = '0;
            end
        end
        checks++;
        if (done_cnt != 5) begin errors++; $display("FAIL rr_done_count got %0d want 5", done_cnt); end
        repeat (4) @(negedge clk);
        checks++;
        if (m_txn[0] - txn0 != 5) begin errors++; $display("FAIL rr_txn got %0d want 5", m_txn[0] - txn0); end
        for (int i = 0; i < 5; i++) begin
            exp = '0;
            checks++;
            if (aq1.size() <= i || aq1[i] !== port_addr(exp_order[i])) begin
                errors++; $display("FAIL rr_address[%0d] n=%0d want %h", i, aq1.size(), port_addr(exp_order[i]));
            end
        end
        aq1.delete();
    endtask

    task automatic test_refresh_stall();
        int good = 0, bad = 0, done_cnt = 0, rv_cnt = 0, txn0;
        logic [DW-1:0] exp;
        txn0 = m_txn[0];
        m_stall[0] = 10;
        b1.req_address[1*AW +: AW] = port_addr(1);
        b1.req_write[1] = 1'b0;
        b1.req_valid[1] = 1'b1;
        for (int c = 0; c < 60 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (b1.sdram_command == 2'd2 && b1.sdram_address == port_addr(1)) good++;
            else if (b1.sdram_command != 2'd0) bad++;
            if (|b1.rd_valid) begin
                rv_cnt++;
                exp = (rq1.size() > 0) ? rq1.pop_front() : 16'hxxxx;
                checks++;
                if (b1.rd_data !== exp || b1.rd_valid !== 4'b0010) begin
                    errors++; $display("FAIL rs_read got %h/%b want %h/0010", b1.rd_data, b1.rd_valid, exp);
                end
            end
            if (b1.req_done[1]) begin done_cnt++; b1.req_valid[1] = 1'b0; end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (good != 14) begin errors++; $display("FAIL rs_cmd_held got %0d want 14", good); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rs_cmd_unstable got %0d want 0", bad); end
        checks++;
        if (m_txn[0] - txn0 != 1) begin errors++; $display("FAIL rs_txn got %0d want 1", m_txn[0] - txn0); end
        checks++;
        if (done_cnt != 1 || rv_cnt != 1) begin errors++; $display("FAIL rs_done_rv got %0d/%0d want 1/1", done_cnt, rv_cnt); end
        aq1.delete();
    endtask

    task automatic test_reset_mid_burst();
        int rv_cnt = 0, stale = 0, done_cnt = 0;
        logic [DW-1:0] exp;
        rq4.delete(); aq4.delete();
        b4.req_address[1*AW +: AW] = port_addr(1);
        b4.req_write[1] = 1'b0;
        b4.req_valid[1] = 1'b1;
        for (int c = 0; c < 40 && rv_cnt < 2; c++) begin
            @(negedge clk);
            if (|b4.rd_valid) begin
                rv_cnt++;
                exp = (rq4.size() > 0) ? rq4.pop_front() : 16'hxxxx;
                checks++;
                if (b4.rd_data !== exp || b4.rd_valid !== 4'b0010) begin
                    errors++; $display("FAIL rm_pre_read got %h/%b want %h/0010", b4.rd_data, b4.rd_valid, exp);
                end
            end
        end
        checks++;
        if (rv_cnt != 2) begin errors++; $display("FAIL rm_reach_mid got %0d want 2", rv_cnt); end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({b4.sdram_command, b4.rd_valid, b4.req_done, b4.req_wbeat} !== '0) begin
            errors++; $display("FAIL rm_async_ctl got %h want 0", {b4.sdram_command, b4.rd_valid, b4.req_done, b4.req_wbeat});
        end
        checks++;
        if (b4.rd_data !== '0) begin errors++; $display("FAIL rm_async_rd_data got %h want 0", b4.rd_data); end
        b4.req_valid = '0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b4.rd_valid != 4'b0 || b4.req_done != 4'b0 || b4.sdram_command != 2'd0) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL rm_stale_beats got %0d want 0", stale); end
        rq4.delete(); aq4.delete();
        rv_cnt = 0;
        b4.req_address[3*AW +: AW] = port_addr(3);
        b4.req_write[3] = 1'b0;
        b4.req_valid[3] = 1'b1;
        for (int c = 0; c < 60 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (|b4.rd_valid) begin
                rv_cnt++;
                exp = (rq4.size() > 0) ? rq4.pop_front() : 16'hxxxx;
                checks++;
                if (b4.rd_data !== exp || b4.rd_valid !== 4'b1000) begin
                    errors++; $display("FAIL rm_post_read got %h/%b want %h/1000", b4.rd_data, b4.rd_valid, exp);
                end
            end
            if (|b4.req_done) begin
                done_cnt++;
                checks++;
                if (b4.req_done !== 4'b1000) begin errors++; $display("FAIL rm_post_done got %b want 1000", b4.req_done); end
                b4.req_valid[3] = 1'b0;
            end
        end
        checks++;
        if (done_cnt != 1 || rv_cnt != 4) begin errors++; $display("FAIL rm_post_counts got %0d/%0d want 1/4", done_cnt, rv_cnt); end
        checks++;
        if (aq4.size() != 1 || aq4[0] !== port_addr(3)) begin errors++; $display("FAIL rm_post_address n=%0d want %h", aq4.size(), port_addr(3)); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_cnt[d] = 0; m_beat[d] = 0; m_stall[d] = 0;
            m_lat[d] = 2; m_txn[d] = 0; m_wr[d] = 1'b0; m_seq[d] = '0;
        end
        b1.req_valid = '0; b1.req_write = '0; b1.req_address = '0; b1.req_wdata = '0;
        b4.req_valid = '0; b4.req_write = '0; b4.req_address = '0; b4.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_read();
        test_burst_write();
        test_round_robin();
        test_refresh_stall();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
